// File: rtl/dac_pwm_out.sv
// Audio PWM output stage: shapes the DAC ramp, scales it by volume and emits a
// 2^DATA_W-clock PWM. Optional dither via `define DAC_PWM_DITHER_EN.
module dac_pwm_out #(
    parameter int DATA_W = 8,
    parameter int VOL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dacCount,
    input  logic [1:0]        wave_sel,
    input  logic [VOL_W-1:0]  volume,
    input  logic              enable,
    output logic              pwm_o,
    output logic              sample_stb,
    output logic              busy
);

    typedef enum logic [1:0] {OFF, PLAY, DRAIN} state_t;

    state_t              state;
    logic [DATA_W-1:0]   pwm_cnt;
    logic [DATA_W-1:0]   duty_q;
    logic [DATA_W-1:0]   shaped;
    logic [DATA_W-1:0]   tri_lin;
    logic [VOL_W:0]      vol_p1;
    logic [DATA_W+VOL_W-1:0] prod;
    logic [DATA_W-1:0]   scaled;
    logic [DATA_W-1:0]   load_val;
    logic                term;
    logic                load;

    assign term = (pwm_cnt == {DATA_W{1'b1}});
    // Every load happens at a period boundary with enable high, whatever the state.
    assign load = term && enable;

    always_comb begin
        tri_lin = {dacCount[DATA_W-2:0], 1'b0};
        shaped  = '0;
        case (wave_sel)
            2'd0:    shaped = dacCount;
            2'd1:    shaped = dacCount[DATA_W-1] ? ~tri_lin : tri_lin;
            2'd2:    shaped = {DATA_W{dacCount[DATA_W-1]}};
            default: shaped = '0;
        endcase
    end

    assign vol_p1 = {1'b0, volume} + {{VOL_W{1'b0}}, 1'b1};
    assign prod   = {{VOL_W{1'b0}}, shaped} * {{(DATA_W-1){1'b0}}, vol_p1};
    assign scaled = prod[DATA_W+VOL_W-1:VOL_W];

`ifdef DAC_PWM_DITHER_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else if (load) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign load_val = (scaled == {DATA_W{1'b1}}) ? scaled
                    : scaled + {{(DATA_W-1){1'b0}}, lfsr[0]};
`else
    assign load_val = scaled;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt    <= '0;
            duty_q     <= '0;
            state      <= OFF;
            sample_stb <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            sample_stb <= load;
            if (load) begin
                duty_q <= load_val;
            end else if (term) begin
                duty_q <= '0;
            end
            case (state)
                OFF:     if (load) state <= PLAY;
                PLAY:    if (!enable) state <= term ? OFF : DRAIN;
                DRAIN:   if (term) state <= enable ? PLAY : OFF;
                default: state <= OFF;
            endcase
        end
    end

    assign pwm_o = (state != OFF) && (pwm_cnt < duty_q);
    assign busy  = (state != OFF);

endmodule

// File: tb/tb_dac_pwm_out.sv
// Directed bench for dac_pwm_out: expected high-cycle counts per PWM period
// are queued with the stimulus and checked as each period plays out.
module tb_dac_pwm_out;

    logic       tb_clk;
    logic       rst;
    logic [7:0] dacCount;
    logic [1:0] wave_sel;
    logic [2:0] volume;
    logic       enable;
    logic       pwm_o;
    logic       sample_stb;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic [7:0] model_cnt;

    dac_pwm_out #(.DATA_W(8), .VOL_W(3)) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .dacCount   (dacCount),
        .wave_sel   (wave_sel),
        .volume     (volume),
        .enable     (enable),
        .pwm_o      (pwm_o),
        .sample_stb (sample_stb),
        .busy       (busy)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Free-running period position, used only to find cnt values in time.
    always @(posedge tb_clk or posedge rst) begin
        if (rst) model_cnt <= 8'd0;
        else     model_cnt <= model_cnt + 8'd1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cnt(input int n);
        int k = 0;
        @(negedge tb_clk);
        while (int'(model_cnt) != n && k < 600) begin
            @(negedge tb_clk);
            k++;
        end
        check("sync", int'(model_cnt), n);
    endtask

    task automatic measure_period(input string tag, input int dac_at, input logic [7:0] dac_val,
                                  input int off_at, input int on_at);
        int hi = 0;
        int stbs = 0;
        int exp_hi = -1;
        wait_cnt(0);
        check({tag, "_stb0"}, int'(sample_stb), 1);
        check({tag, "_busy0"}, int'(busy), 1);
        for (int i = 0; i < 256; i++) begin
            hi   += int'(pwm_o);
            stbs += int'(sample_stb);
            if (i == dac_at) dacCount = dac_val;
            if (i == off_at) enable = 1'b0;
            if (i == on_at)  enable = 1'b1;
            if (i != 255) @(negedge tb_clk);
        end
        check({tag, "_qpending"}, int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) exp_hi = exp_q.pop_front();
        check({tag, "_high"}, hi, exp_hi);
        check({tag, "_stbcnt"}, stbs, 1);
    endtask

    initial begin
        int hi;
        int bsy;
        int stbs;
        rst = 1'b1; enable = 1'b0; wave_sel = 2'd0; volume = 3'd0; dacCount = 8'd0;
        repeat (2) @(negedge tb_clk);
        check("rst_pwm", int'(pwm_o), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_stb", int'(sample_stb), 0);

        // First period after reset stays idle while enable waits for T.
        rst = 1'b0;
        enable = 1'b1; wave_sel = 2'd0; volume = 3'd7; dacCount = 8'd64;
        exp_q.push_back(64);
        hi = 0; bsy = 0; stbs = 0;
        for (int i = 0; i < 256; i++) begin
            hi += int'(pwm_o); bsy += int'(busy); stbs += int'(sample_stb);
            if (i != 255) @(negedge tb_clk);
        end
        check("idle_pwm", hi, 0);
        check("idle_busy", bsy, 0);
        check("idle_stb", stbs, 0);
        measure_period("saw64", -1, 8'd0, -1, -1);
        exp_q.push_back(64);
        measure_period("saw64b", -1, 8'd0, -1, -1);

        wave_sel = 2'd1; volume = 3'd3; dacCount = 8'd200;
        exp_q.push_back(55);
        measure_period("tri200", -1, 8'd0, -1, -1);

        wave_sel = 2'd2; dacCount = 8'd127;
        exp_q.push_back(0);
        measure_period("sq127", -1, 8'd0, -1, -1);
        dacCount = 8'd128; volume = 3'd7;
        exp_q.push_back(255);
        measure_period("sq128", -1, 8'd0, -1, -1);
        wave_sel = 2'd3;
        exp_q.push_back(0);
        measure_period("silence", -1, 8'd0, -1, -1);

        // Mid-period dacCount change only affects the following period.
        wave_sel = 2'd0; volume = 3'd0; dacCount = 8'd255;
        exp_q.push_back(31);
        exp_q.push_back(1);
        measure_period("minvol", 100, 8'd10, -1, -1);
        measure_period("minvol10", -1, 8'd0, -1, -1);

        volume = 3'd7; dacCount = 8'd64;
        exp_q.push_back(64);
        measure_period("drop", -1, 8'd0, 20, -1);
        wait_cnt(0);
        check("off_busy", int'(busy), 0);
        check("off_pwm", int'(pwm_o), 0);
        check("off_stb", int'(sample_stb), 0);
        enable = 1'b1;
        exp_q.push_back(64);
        measure_period("reen", -1, 8'd0, -1, -1);

        exp_q.push_back(64);
        exp_q.push_back(64);
        measure_period("drain", -1, 8'd0, 20, 100);
        measure_period("nogap", -1, 8'd0, -1, -1);

        wait_cnt(30);
        check("pre_rst_pwm", int'(pwm_o), 1);
        #1 rst = 1'b1;
        #1;
        check("async_pwm", int'(pwm_o), 0);
        check("async_busy", int'(busy), 0);
        check("async_stb", int'(sample_stb), 0);
        @(negedge tb_clk);
        rst = 1'b0;
        @(negedge tb_clk);
        check("post_rst_busy", int'(busy), 0);
        check("q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
